// File: rtl/led_pkg.sv
// Shared constants and types for the LED pattern generator and PWM output stage.
package led_pkg;

    localparam int unsigned LEVEL_W        = 8;
    localparam int unsigned N_LED_DEF      = 8;
    localparam int unsigned CLK_FREQ       = 100_000_000;
    localparam int unsigned PWM_DIV_DEF    = 390;
    localparam int unsigned DECAY_DIV_DEF  = 1_000_000;
    localparam int unsigned DECAY_STEP_DEF = 16;

    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        LedOff,
        LedBlink,
        LedCounter,
        LedKnight
    } led_mode_e;

    // Widened subtraction so a borrow clamps to zero instead of wrapping.
    function automatic level_t level_sat_sub(level_t a, level_t b);
        logic [LEVEL_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[LEVEL_W] ? '0 : diff[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/led_ce_div.sv
// Generic clock-enable divider: ce_out pulses for one cycle every DIV clocks.
module led_ce_div
    import led_pkg::*;
#(
    parameter int unsigned DIV = PWM_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic ce_out
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // With DIV == 1 the counter is stuck at 0 == LAST, so ce_out stays high.
    assign ce_out = (cnt == LAST);

endmodule

// File: rtl/led_pwm_fader.sv
// LED output stage: per-channel PWM with global brightness and linear afterglow.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned N_LED      = N_LED_DEF,
    parameter int unsigned PWM_DIV    = PWM_DIV_DEF,
    parameter int unsigned DECAY_DIV  = DECAY_DIV_DEF,
    parameter int unsigned DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LED-1:0]   led_in,
    input  logic [LEVEL_W-1:0] brightness,
    input  logic               fade_en,
    output logic [N_LED-1:0]   led_out,
    output logic               pwm_sync
);

    localparam level_t STEP = level_t'(DECAY_STEP);

    logic   pwm_ce;
    logic   decay_tick;
    level_t pwm_cnt;

    led_ce_div #(
        .DIV (PWM_DIV)
    ) u_pwm_div (
        .clk    (clk),
        .rst    (rst),
        .ce_out (pwm_ce)
    );

    led_ce_div #(
        .DIV (DECAY_DIV)
    ) u_decay_div (
        .clk    (clk),
        .rst    (rst),
        .ce_out (decay_tick)
    );

    // pwm_sync marks the first cycle in which pwm_cnt reads 0 after a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            pwm_sync <= 1'b0;
        end else begin
            pwm_sync <= pwm_ce && (pwm_cnt == '1);
            if (pwm_ce) begin
                pwm_cnt <= pwm_cnt + level_t'(1);
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_led
        level_t level;
        logic   out_bit;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level <= '0;
            end else if (led_in[i]) begin
                level <= brightness;
            end else if (!fade_en) begin
                level <= '0;
            end else if (decay_tick) begin
                level <= level_sat_sub(level, STEP);
            end
        end

        // Full scale is solid on; otherwise duty is level/256.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_bit <= 1'b0;
            end else begin
                out_bit <= (level == '1) || (pwm_cnt < level);
            end
        end

        assign led_out[i] = out_bit;
    end

endmodule
